// File: rtl/axi_rom_slave_pkg.sv
// Shared AXI3 encodings, FSM state types and read-request payload for the ROM slave.
package axi_rom_slave_pkg;

    localparam int unsigned ID_W       = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned SIZE_W     = 3;
    localparam int unsigned BURST_W    = 2;
    localparam int unsigned RESP_W     = 2;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [BURST_W-1:0] BURST_WRAP = 2'b10;
    localparam logic [BURST_W-1:0] BURST_RSVD = 2'b11;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    localparam logic [SIZE_W-1:0] SIZE_WORD = 3'b010;

    typedef enum logic [3:0] {
        R_IDLE  = 4'b0001,
        R_ISSUE = 4'b0010,
        R_WAIT  = 4'b0100,
        R_DATA  = 4'b1000
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]      len;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
    } ar_req_t;

    // Decode error outranks an unsupported size/burst.
    function automatic logic [RESP_W-1:0] beat_resp(input logic in_window,
                                                   input logic [SIZE_W-1:0] size,
                                                   input logic [BURST_W-1:0] burst);
        if (!in_window) begin
            return RESP_DECERR;
        end
        if (size != SIZE_WORD || burst == BURST_WRAP || burst == BURST_RSVD) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_wr_sink.sv
// Write channel sink: accepts one AW, drains its W beats, answers SLVERR on B.
module axi_wr_sink
    import axi_rom_slave_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   awid,
    input  logic              awvalid,
    output logic              awready,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [RESP_W-1:0] bresp,
    output logic              bvalid,
    input  logic              bready
);

    wr_state_e         state, state_nxt;
    logic [ID_W-1:0]   bid_nxt;
    logic [RESP_W-1:0] bresp_nxt;
    logic              awready_nxt, wready_nxt, bvalid_nxt;

    always_comb begin
        state_nxt = state;
        bid_nxt   = bid;
        unique case (state)
            W_IDLE: begin
                if (awvalid && awready) begin
                    bid_nxt   = awid;
                    state_nxt = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (wvalid && wready && wlast) begin
                    state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    state_nxt = W_IDLE;
                end
            end
            default: state_nxt = W_IDLE;
        endcase
        awready_nxt = (state_nxt == W_IDLE);
        wready_nxt  = (state_nxt == W_DRAIN);
        bvalid_nxt  = (state_nxt == W_RESP);
        bresp_nxt   = (state_nxt == W_RESP) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= W_IDLE;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bid     <= bid_nxt;
            bresp   <= bresp_nxt;
            awready <= awready_nxt;
            wready  <= wready_nxt;
            bvalid  <= bvalid_nxt;
        end
    end

endmodule

// File: rtl/axi_rom_slave.sv
// AXI3 read-only slave in front of a synchronous ROM; writes are drained and refused.
module axi_rom_slave
    import axi_rom_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]      arlen,
    input  logic [SIZE_W-1:0]     arsize,
    input  logic [BURST_W-1:0]    arburst,
    input  logic [1:0]            arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_W-1:0]       rid,
    output logic [DATA_W-1:0]     rdata,
    output logic [RESP_W-1:0]     rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ID_W-1:0]       awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]      awlen,
    input  logic [SIZE_W-1:0]     awsize,
    input  logic [BURST_W-1:0]    awburst,
    input  logic [1:0]            awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_W-1:0]       wid,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_W-1:0]       bid,
    output logic [RESP_W-1:0]     bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Range check runs per beat on the current address, not once per burst.
    function automatic logic [RESP_W-1:0] resp_of(input ar_req_t r);
        return beat_resp(r.addr[AXI_ADDR_W-1:ADDR_W+2] == BASE_ADDR[AXI_ADDR_W-1:ADDR_W+2],
                         r.size, r.burst);
    endfunction

    rd_state_e         state, state_nxt;
    ar_req_t           req, req_nxt;
    logic [LEN_W-1:0]  beat, beat_nxt;
    logic [ID_W-1:0]   rid_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [RESP_W-1:0] rresp_nxt, cur_resp, nxt_resp;
    logic              rlast_nxt, arready_nxt, rvalid_nxt, mem_en_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;

    always_comb begin
        state_nxt = state;
        req_nxt   = req;
        beat_nxt  = beat;
        rid_nxt   = rid;
        rdata_nxt = rdata;
        rresp_nxt = rresp;
        rlast_nxt = rlast;
        cur_resp  = resp_of(req);
        unique case (state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    req_nxt   = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
                    beat_nxt  = '0;
                    state_nxt = R_ISSUE;
                end
            end
            R_ISSUE: state_nxt = R_WAIT;
            R_WAIT: begin
                rid_nxt   = req.id;
                rdata_nxt = (cur_resp == RESP_OKAY) ? mem_rdata : '0;
                rresp_nxt = cur_resp;
                rlast_nxt = (beat == req.len);
                state_nxt = R_DATA;
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    beat_nxt = beat + LEN_W'(1);
                    if (rlast) begin
                        state_nxt = R_IDLE;
                    end else begin
                        if (req.burst == BURST_INCR) begin
                            req_nxt.addr = req.addr + AXI_ADDR_W'(4);
                        end
                        state_nxt = R_ISSUE;
                    end
                end
            end
            default: state_nxt = R_IDLE;
        endcase
        // Interface strobes are registered, so derive them from the upcoming state.
        nxt_resp     = resp_of(req_nxt);
        arready_nxt  = (state_nxt == R_IDLE);
        rvalid_nxt   = (state_nxt == R_DATA);
        mem_en_nxt   = (state_nxt == R_ISSUE) && (nxt_resp == RESP_OKAY);
        mem_addr_nxt = (state_nxt == R_ISSUE) ? req_nxt.addr[ADDR_W+1:2] : mem_addr;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= R_IDLE;
            req      <= '0;
            beat     <= '0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rlast    <= 1'b0;
            rvalid   <= 1'b0;
            arready  <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            req      <= req_nxt;
            beat     <= beat_nxt;
            rid      <= rid_nxt;
            rdata    <= rdata_nxt;
            rresp    <= rresp_nxt;
            rlast    <= rlast_nxt;
            rvalid   <= rvalid_nxt;
            arready  <= arready_nxt;
            mem_en   <= mem_en_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

    axi_wr_sink u_wr_sink (
        .aclk    (aclk),
        .areset  (areset),
        .awid    (awid),
        .awvalid (awvalid),
        .awready (awready),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    // Write payload and cache/lock/prot attributes carry no meaning for a ROM.
    logic unused_in;
    assign unused_in = ^{arlock, arcache, arprot, awaddr, awlen, awsize, awburst,
                         awlock, awcache, awprot, wid, wdata, wstrb};

endmodule

// File: tb/tb_axi_rom_slave.sv
// Directed bench for axi_rom_slave with a synchronous ROM model and hand-computed expectations.
module tb_axi_rom_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = '0;

    axi_rom_slave dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [11:0] mq[$];
    int          mcyc[$];

    // ROM content: word address in the low bits of a fixed tag.
    always @(posedge aclk) begin
        if (mem_en) begin
            mem_rdata <= 32'hC0DE_0000 | 32'(mem_addr);
            mq.push_back(mem_addr);
            mcyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] g_data[16];
    logic [1:0]  g_resp[16];
    logic        g_last[16];
    logic [3:0]  g_id[16];
    int          nb, first_lat, ar_cyc, aw_cyc;
    logic        gap_ok, stable_ok;
    logic        got_bvalid;
    logic [3:0]  got_bid;
    logic [1:0]  got_bresp;

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
        int b, last_hs;
        logic done;
        mq.delete();
        mcyc.delete();
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        b = 0;
        while (!arready && b < 20) begin @(posedge aclk); #1; b++; end
        if (!arready) begin
            check("ar_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            return;
        end
        ar_cyc = cyc;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        nb = 0; done = 1'b0; b = 0; last_hs = ar_cyc; gap_ok = 1'b1; stable_ok = 1'b1; first_lat = -1;
        while (!done && b < 200 && nb < 16) begin
            if (rvalid) begin
                if (nb == 0) first_lat = cyc - ar_cyc;
                else if (cyc - last_hs != 3) gap_ok = 1'b0;
                g_data[nb] = rdata; g_resp[nb] = rresp; g_last[nb] = rlast; g_id[nb] = rid;
                if (nb == stall_beat) begin
                    for (int k = 0; k < 5; k++) begin
                        @(posedge aclk); #1;
                        if (!rvalid || rdata !== g_data[nb] || rid !== g_id[nb] ||
                            rlast !== g_last[nb] || rresp !== g_resp[nb]) stable_ok = 1'b0;
                    end
                end
                rready = 1'b1;
                last_hs = cyc;
                done = rlast;
                nb++;
                @(posedge aclk); #1;
                rready = 1'b0;
            end else begin
                @(posedge aclk); #1;
            end
            b++;
        end
        if (!done) check("r_timeout", 32'(done), 32'd1);
    endtask

    task automatic write_burst(input logic [3:0] id, input int nbeats);
        int b;
        awid = id; awaddr = 32'h1FC0_0000; awlen = 4'(nbeats - 1); awsize = 3'b010;
        awburst = 2'b01; awvalid = 1'b1;
        b = 0;
        while (!awready && b < 20) begin @(posedge aclk); #1; b++; end
        aw_cyc = awready ? cyc : -1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wid = id; wdata = $urandom; wstrb = 4'hF; wlast = (i == nbeats - 1); wvalid = 1'b1;
            b = 0;
            while (!wready && b < 20) begin @(posedge aclk); #1; b++; end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        b = 0;
        while (!bvalid && b < 20) begin @(posedge aclk); #1; b++; end
        got_bvalid = bvalid; got_bid = bid; got_bresp = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("b_drop", 32'(bvalid), 32'd0);
    endtask

    // Common per-beat id/last checks; data and resp are checked by each case.
    task automatic check_beats(input string tag, input int n, input logic [3:0] id);
        check({tag, "_nbeats"}, 32'(nb), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_rid%0d", tag, i), 32'(g_id[i]), 32'(id));
            check($sformatf("%s_rlast%0d", tag, i), 32'(g_last[i]), 32'(i == n - 1));
        end
    endtask

    task automatic check_mem(input string tag, input int n, input logic [11:0] first, input logic incr);
        check({tag, "_mem_cnt"}, 32'(mq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_mem_addr%0d", tag, i),
                  (i < mq.size()) ? 32'(mq[i]) : 32'hFFFF_FFFF,
                  32'(first) + (incr ? 32'(i) : 32'd0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        got_bvalid = 1'b0; got_bid = '0; got_bresp = '0;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rid_bid", 32'({rid, bid, rresp}), 32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("rel_arready", 32'(arready), 32'd1);
        check("rel_awready", 32'(awready), 32'd1);

        // Case 1: plain INCR burst, words 4..7
        read_burst(4'd3, 32'h1FC0_0010, 4'd3, 3'b010, 2'b01, -1);
        check_beats("c1", 4, 4'd3);
        check_mem("c1", 4, 12'd4, 1'b1);
        check("c1_first_lat", 32'(first_lat), 32'd3);
        check("c1_mem_en_cyc", (mcyc.size() > 0) ? 32'(mcyc[0] - ar_cyc) : 32'hFFFF_FFFF, 32'd1);
        check("c1_gap", 32'(gap_ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c1_data%0d", i), g_data[i], 32'hC0DE_0004 + 32'(i));
            check($sformatf("c1_resp%0d", i), 32'(g_resp[i]), 32'd0);
        end

        // Case 2: back-pressure on beat 1
        read_burst(4'd7, 32'h1FC0_0010, 4'd3, 3'b010, 2'b01, 1);
        check_beats("c2", 4, 4'd7);
        check_mem("c2", 4, 12'd4, 1'b1);
        check("c2_stable", 32'(stable_ok), 32'd1);
        for (int i = 0; i < 4; i++)
            check($sformatf("c2_data%0d", i), g_data[i], 32'hC0DE_0004 + 32'(i));

        // Case 3: burst running off the end of the window
        read_burst(4'd1, 32'h1FC0_3FF8, 4'd3, 3'b010, 2'b01, -1);
        check_beats("c3", 4, 4'd1);
        check_mem("c3", 2, 12'hFFE, 1'b1);
        check("c3_data0", g_data[0], 32'hC0DE_0FFE);
        check("c3_data1", g_data[1], 32'hC0DE_0FFF);
        check("c3_data2", g_data[2], 32'h0);
        check("c3_data3", g_data[3], 32'h0);
        check("c3_resp", 32'({g_resp[0], g_resp[1], g_resp[2], g_resp[3]}), 32'b00_00_11_11);

        // Case 4: unsupported WRAP, unsupported size, then FIXED
        read_burst(4'd2, 32'h1FC0_0000, 4'd1, 3'b010, 2'b10, -1);
        check_beats("c4w", 2, 4'd2);
        check("c4w_mem_cnt", 32'(mq.size()), 32'd0);
        check("c4w_resp", 32'({g_resp[0], g_resp[1]}), 32'b10_10);
        check("c4w_data", g_data[0] | g_data[1], 32'h0);
        read_burst(4'd2, 32'h1FC0_0000, 4'd1, 3'b001, 2'b01, -1);
        check_beats("c4s", 2, 4'd2);
        check("c4s_mem_cnt", 32'(mq.size()), 32'd0);
        check("c4s_resp", 32'({g_resp[0], g_resp[1]}), 32'b10_10);
        check("c4s_data", g_data[0] | g_data[1], 32'h0);
        read_burst(4'd9, 32'h1FC0_0020, 4'd2, 3'b010, 2'b00, -1);
        check_beats("c4f", 3, 4'd9);
        check_mem("c4f", 3, 12'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("c4f_data%0d", i), g_data[i], 32'hC0DE_0008);
            check($sformatf("c4f_resp%0d", i), 32'(g_resp[i]), 32'd0);
        end

        // Case 5: write burst concurrent with a read burst
        fork
            write_burst(4'd5, 4);
            read_burst(4'd6, 32'h1FC0_0040, 4'd3, 3'b010, 2'b01, -1);
        join
        check("c5_same_cycle", 32'(aw_cyc), 32'(ar_cyc));
        check("c5_bvalid", 32'(got_bvalid), 32'd1);
        check("c5_bid", 32'(got_bid), 32'd5);
        check("c5_bresp", 32'(got_bresp), 32'b10);
        check_beats("c5", 4, 4'd6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c5_data%0d", i), g_data[i], 32'hC0DE_0010 + 32'(i));
            check($sformatf("c5_resp%0d", i), 32'(g_resp[i]), 32'd0);
        end

        // Case 6: reset while beat 1 is presented
        arid = 4'd4; araddr = 32'h1FC0_0010; arlen = 4'd3; arsize = 3'b010; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        check("c6_beat1_valid", 32'(rvalid), 32'd1);
        check("c6_beat1_data", rdata, 32'hC0DE_0005);
        areset = 1'b1;
        #1;
        check("c6_rvalid_rst", 32'(rvalid), 32'd0);
        check("c6_mem_en_rst", 32'(mem_en), 32'd0);
        check("c6_rdata_rst", rdata, 32'd0);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        areset = 1'b0;
        mq.delete();
        @(posedge aclk); #1;
        check("c6_arready", 32'(arready), 32'd1);
        n = 0;
        repeat (6) begin
            @(posedge aclk); #1;
            if (rvalid || mem_en) n++;
        end
        check("c6_no_stray", 32'(n), 32'd0);
        read_burst(4'd8, 32'h1FC0_0010, 4'd3, 3'b010, 2'b01, -1);
        check_beats("c6", 4, 4'd8);
        check_mem("c6", 4, 12'd4, 1'b1);
        for (int i = 0; i < 4; i++)
            check($sformatf("c6_data%0d", i), g_data[i], 32'hC0DE_0004 + 32'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rom_slave.md
AXI_ROM_SLAVE -- requirements
Module: axi_rom_slave

Interface
REQ-001 Parameters (name, default, meaning): BASE_ADDR, 32'h1FC0_0000, byte base of the decoded window.
REQ-002 ADDR_W, 12, word-address width; the window is 2^ADDR_W words.
REQ-003 Ports (name, direction, width, meaning): aclk, in, 1, the only clock; all logic is on its rising edge.
REQ-004 areset, in, 1, asynchronous, active-high reset.
REQ-005 arid/araddr/arlen/arsize/arburst, in, 4/32/4/3/2; arlock/arcache/arprot, in, 2/4/3, ignored; arvalid, in, 1; arready, out, 1.
REQ-006 rid/rdata/rresp, out, 4/32/2; rlast/rvalid, out, 1; rready, in, 1.
REQ-007 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, in, AXI3 widths; awready, out, 1.
REQ-008 wid/wdata/wstrb/wlast/wvalid, in, 4/32/4/1/1; wready, out, 1.
REQ-009 bid/bresp, out, 4/2; bvalid, out, 1; bready, in, 1.
REQ-010 mem_en, out, 1, read strobe to the synchronous memory.
REQ-011 mem_addr, out, ADDR_W, word address to the memory.
REQ-012 mem_rdata, in, 32, read data, valid the cycle after mem_en.

Function
REQ-013 The read FSM SHALL use one-hot states R_IDLE=4'b0001, R_ISSUE=4'b0010, R_WAIT=4'b0100, R_DATA=4'b1000.
REQ-014 arready SHALL equal 1 only in R_IDLE; one burst is outstanding at a time.
REQ-015 On an AR handshake the block SHALL latch arid, araddr, arlen, arsize and arburst, clear the beat counter and move to R_ISSUE.
REQ-016 R_ISSUE: mem_en=1 only for a non-error beat; mem_addr=cur_addr[ADDR_W+1:2]; next state R_WAIT.
REQ-017 R_WAIT: rdata SHALL capture mem_rdata, or 32'h0 for an error beat; next state R_DATA.
REQ-018 R_DATA: rvalid=1; rid, rdata, rresp and rlast SHALL hold stable until rready.
REQ-019 On handshake with rlast=0 the FSM SHALL go to R_ISSUE; with rlast=1 it SHALL go to R_IDLE.
REQ-020 Latency: AR handshake in cycle t gives mem_en in t+1 and first rvalid in t+3; each further beat follows its predecessor's handshake by 3 cycles.
REQ-021 rlast SHALL be 1 exactly when beat count equals the latched arlen; a burst is arlen+1 beats, 1..16.
REQ-022 The next address SHALL be cur_addr+4 for INCR (2'b01), computed modulo 2^32, and unchanged for FIXED (2'b00).
REQ-023 rresp SHALL be 2'b11 (DECERR) for a beat whose cur_addr[31:ADDR_W+2] differs from BASE_ADDR[31:ADDR_W+2].
REQ-024 Otherwise rresp SHALL be 2'b10 (SLVERR) if arsize is not 3'b010 or arburst is 2'b10 or 2'b11.
REQ-025 Otherwise rresp SHALL be 2'b00; the range check is evaluated per beat, so an INCR burst crossing the window end errors only its out-of-range beats.
REQ-026 The write path SHALL be independent, with states W_IDLE -> W_DRAIN -> W_RESP -> W_IDLE.
REQ-027 W_IDLE: awready=1; on handshake latch awid.
REQ-028 W_DRAIN: wready=1; every beat is discarded; leave on a handshake with wlast=1.
REQ-029 W_RESP: bvalid=1, bid=latched awid, bresp=2'b10, held until bready.
REQ-030 Simultaneous AR and AW handshakes SHALL both be accepted in the same cycle.
REQ-031 Memory SHALL never be written.

Reset
REQ-032 While areset=1: both FSMs in IDLE; arready=0, awready=0, wready=0, rvalid=0, bvalid=0, mem_en=0; rdata, rid, rresp, bid and counters are 0.
REQ-033 arready and awready SHALL return to 1 on the first aclk edge after areset deasserts.
REQ-034 Reset mid-burst SHALL abandon the burst with no further beats and no partial response.

Structure
REQ-035 AXI burst and response encodings and FSM state constants SHALL live in the shared defines include.
REQ-036 The write path SHALL be one sub-module, axi_wr_sink; the read FSM stays in the top.

Verification
REQ-037 Case 1: araddr=32'h1FC0_0010, arlen=3, INCR, rready=1 -> mem_addr 4,5,6,7; four beats of memory data; rresp=00; rlast on beat 3; first rvalid 3 cycles after AR.
REQ-038 Case 2: same burst with rready=0 for 5 cycles on beat 1 -> rdata, rid and rlast stable throughout; no extra mem_en.
REQ-039 Case 3: araddr=32'h1FC0_3FF8, arlen=3, INCR -> beats 0-1 rresp=00; beats 2-3 rresp=11 with rdata=0 and no mem_en.
REQ-040 Case 4: arburst=2'b10 or arsize=3'b001 -> all beats rresp=10, rdata=0; FIXED arlen=2 -> mem_addr constant.
REQ-041 Case 5: AW awid=5 plus 4 W beats concurrent with a read burst -> bvalid with bid=5, bresp=10; read data unaffected.
REQ-042 Case 6: areset pulse during R_DATA of beat 1 -> rvalid falls immediately; after release arready=1 and a new burst completes normally.
